memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Bexkat1 pipeline stage directly downstream of execute. Passes non-memory
//  instructions through in one cycle. Turns T_LOAD/T_STORE into one bus cycle
//  on a single-master, Wishbone-style data port, using the effective address
//  from execute's result. Stalls upstream until ack/err; feeds writeback.
// PARAMETERS
//  AWIDTH  32  bus address width; low AWIDTH bits of result_i drive bus_adr_o
// PORTS
//  clk_i        in   1   clock, all state on rising edge
//  rst_ni       in   1   reset, asynchronous, active-low
//  ir_i         in   64  instruction from execute (ext word in [63:32])
//  pc_i         in   32  pc from execute
//  result_i     in   32  ALU result / effective address from execute
//  reg_data1_i  in   32  ra value; store data
//  reg_write_i  in   2   writeback enables from execute
//  halt_i       in   1   halt from execute
//  ir_o         out  64  instruction to writeback
//  pc_o         out  32  pc to writeback
//  result_o     out  32  load data or forwarded result_i
//  reg_write_o  out  2   writeback enables; forced 0 on bubble/fault
//  halt_o       out  1   registered halt_i, sticky once set
//  stall_o      out  1   comb; upstream holds all inputs while high
//  exc_o        out  1   one-cycle pulse: misaligned access or bus_err_i
//  bus_cyc_o    out  1   bus cycle active
//  bus_stb_o    out  1   strobe (== bus_cyc_o)
//  bus_we_o     out  1   1 = store
//  bus_adr_o    out  AWIDTH  byte address
//  bus_sel_o    out  4   byte lanes, big-endian: sel[3] = bits 31:24 = addr%4==0
//  bus_dat_o    out  32  store data, replicated into selected lanes
//  bus_dat_i    in   32  read data
//  bus_ack_i    in   1   transfer complete
//  bus_err_i    in   1   transfer failed
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; bus_cyc_o/stb_o drop asynchronously.
//  Size from ir_i[25:24]: 00 word, 01 half, 10 byte, 11 treated as word.
//  Misaligned: half with adr[0]=1, word with adr[1:0]!=0 -> no bus cycle.
//  States IDLE, BUS:
//   IDLE, non-mem ir_i: outputs <= inputs next edge (1-cycle), stall_o=0.
//   IDLE, mem ir_i aligned: stall_o=1; next edge -> BUS, bus regs loaded,
//     output regs <= bubble (ir_o=0, reg_write_o=0, pc_o/result_o=0).
//   IDLE, mem ir_i misaligned: stall_o=0; next edge outputs take ir/pc,
//     reg_write_o=0, exc_o=1 for one cycle; no state change.
//   BUS, no ack/err: stall_o=1, bus signals held, outputs stay bubble.
//   BUS, bus_ack_i: stall_o=0; next edge -> IDLE, cyc/stb low, outputs
//     <= ir/pc/reg_write; load result_o = selected lanes zero-extended,
//     store result_o = result_i.
//   BUS, bus_err_i (wins if ack same cycle): as ack but reg_write_o=0,
//     exc_o=1.
//  Minimum load/store latency: 2 cycles in stage; +1 per bus wait cycle.
//  Store lanes: byte dat_o={4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  halt_o: set when halt_i captured; cleared only by reset.
//  No back-to-back bus cycles: IDLE always separates two transfers.
//  bus_cyc_o never asserts without a valid mem op captured in IDLE.
// STRUCTURE
//  bexkat1Def (shared pkg) gains: memsize_t {MS_WORD,MS_HALF,MS_BYTE} and
//  memstate_t {MS_IDLE,MS_BUS}; reuse existing T_LOAD/T_STORE constants.
//  One sub-module: mem_lanes (comb) - size + adr[1:0] -> sel, dat_o,
//  extracted load data, misaligned flag. Everything else in memory_stage.
// TESTING
//  1 T_ALU, result_i=32'h1234 -> next edge result_o=32'h1234, stall_o=0.
//  2 word load adr 32'h100, ack after 3 waits, dat_i=32'hDEADBEEF ->
//    sel=4'hF, we=0, stall high 4 cycles, result_o=32'hDEADBEEF.
//  3 byte store adr 32'h103, d=32'h000000A5 -> sel=4'b0001,
//    dat_o=32'hA5A5A5A5, we=1; half load adr 2 dat_i=32'h11223344 ->
//    result_o=32'h00003344.
//  4 half load adr 32'h101 -> no cyc, exc_o pulse, reg_write_o=0.
//  5 bus_err_i and bus_ack_i same cycle -> exc_o=1, reg_write_o=0.
//  6 rst_ni low mid-BUS -> cyc/stb/stall drop at once; after release
//    a T_MOV passes through in 1 cycle.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared Bexkat1 definitions used by the memory stage: instruction type codes,
// access size and memory-stage state encodings.
package memory_stage_pkg;

    localparam logic [3:0] T_MOV   = 4'h4;
    localparam logic [3:0] T_ALU   = 4'h6;
    localparam logic [3:0] T_LOAD  = 4'h9;
    localparam logic [3:0] T_STORE = 4'hA;

    typedef enum logic [1:0] {
        MS_WORD = 2'b00,
        MS_HALF = 2'b01,
        MS_BYTE = 2'b10
    } memsize_t;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_BUS  = 1'b1
    } memstate_t;

    // Encoding 2'b11 is reserved and behaves as a word access.
    function automatic memsize_t decode_size(input logic [1:0] f);
        case (f)
            2'b01:   return MS_HALF;
            2'b10:   return MS_BYTE;
            default: return MS_WORD;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_lanes.sv
// Big-endian byte-lane steering: byte enables, replicated store data,
// zero-extended load data and alignment check for one access.
module mem_lanes
    import memory_stage_pkg::*;
(
    input  memsize_t    size_i,
    input  logic [1:0]  adr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    always_comb begin
        sel_o        = 4'hF;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = 1'b0;
        case (size_i)
            MS_BYTE: begin
                // Address 0 is the most significant lane.
                sel_o   = 4'b1000 >> adr_i;
                wdata_o = {4{wdata_i[7:0]}};
                case (adr_i)
                    2'd0:    rdata_o = {24'h0, rdata_i[31:24]};
                    2'd1:    rdata_o = {24'h0, rdata_i[23:16]};
                    2'd2:    rdata_o = {24'h0, rdata_i[15:8]};
                    default: rdata_o = {24'h0, rdata_i[7:0]};
                endcase
            end
            MS_HALF: begin
                misaligned_o = adr_i[0];
                sel_o        = adr_i[1] ? 4'b0011 : 4'b1100;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = adr_i[1] ? {16'h0, rdata_i[15:0]} : {16'h0, rdata_i[31:16]};
            end
            default: begin
                misaligned_o = |adr_i;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Bexkat1 memory stage: passes non-memory instructions through in one cycle and
// turns loads/stores into a single Wishbone-style bus cycle, stalling upstream.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int AWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [63:0]       ir_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       result_i,
    input  logic [31:0]       reg_data1_i,
    input  logic [1:0]        reg_write_i,
    input  logic              halt_i,
    output logic [63:0]       ir_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       result_o,
    output logic [1:0]        reg_write_o,
    output logic              halt_o,
    output logic              stall_o,
    output logic              exc_o,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [AWIDTH-1:0] bus_adr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_dat_o,
    input  logic [31:0]       bus_dat_i,
    input  logic              bus_ack_i,
    input  logic              bus_err_i
);

    memstate_t         state_q, state_d;
    logic              cyc_q, cyc_d, we_q, we_d;
    logic [AWIDTH-1:0] adr_q, adr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       dat_q, dat_d;
    logic [63:0]       ir_q, ir_d;
    logic [31:0]       pc_q, pc_d, result_q, result_d;
    logic [1:0]        rw_q, rw_d;
    logic              halt_q, halt_d, exc_q, exc_d, stall_c;

    logic        is_load, is_store, is_mem, misaligned;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata, lane_rdata;

    assign is_load  = (ir_i[31:28] == T_LOAD);
    assign is_store = (ir_i[31:28] == T_STORE);
    assign is_mem   = is_load | is_store;

    mem_lanes u_lanes (
        .size_i       (decode_size(ir_i[25:24])),
        .adr_i        (result_i[1:0]),
        .wdata_i      (reg_data1_i),
        .rdata_i      (bus_dat_i),
        .sel_o        (lane_sel),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (misaligned)
    );

    // Upstream holds its inputs while stalled, so ir_i/result_i stay valid
    // for the whole bus cycle and can be used again when it completes.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        ir_d     = ir_i;
        pc_d     = pc_i;
        result_d = result_i;
        rw_d     = reg_write_i;
        exc_d    = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (is_mem && misaligned) begin
                    rw_d  = 2'b00;
                    exc_d = 1'b1;
                end else if (is_mem) begin
                    stall_c  = 1'b1;
                    state_d  = MS_BUS;
                    cyc_d    = 1'b1;
                    we_d     = is_store;
                    adr_d    = result_i[AWIDTH-1:0];
                    sel_d    = lane_sel;
                    dat_d    = lane_wdata;
                    ir_d     = '0;
                    pc_d     = '0;
                    result_d = '0;
                    rw_d     = 2'b00;
                end
            end
            default: begin
                if (bus_err_i || bus_ack_i) begin
                    state_d = MS_IDLE;
                    cyc_d   = 1'b0;
                    if (is_load) result_d = lane_rdata;
                    if (bus_err_i) begin
                        rw_d  = 2'b00;
                        exc_d = 1'b1;
                    end
                end else begin
                    stall_c  = 1'b1;
                    ir_d     = '0;
                    pc_d     = '0;
                    result_d = '0;
                    rw_d     = 2'b00;
                end
            end
        endcase
        halt_d = halt_q | (halt_i & ~stall_c);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= MS_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            sel_q    <= '0;
            dat_q    <= '0;
            ir_q     <= '0;
            pc_q     <= '0;
            result_q <= '0;
            rw_q     <= '0;
            halt_q   <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            result_q <= result_d;
            rw_q     <= rw_d;
            halt_q   <= halt_d;
            exc_q    <= exc_d;
        end
    end

    // Gating with rst_ni releases upstream immediately when reset asserts.
    assign stall_o     = rst_ni & stall_c;
    assign bus_cyc_o   = cyc_q;
    assign bus_stb_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_adr_o   = adr_q;
    assign bus_sel_o   = sel_q;
    assign bus_dat_o   = dat_q;
    assign ir_o        = ir_q;
    assign pc_o        = pc_q;
    assign result_o    = result_q;
    assign reg_write_o = rw_q;
    assign halt_o      = halt_q;
    assign exc_o       = exc_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed scoreboard bench for memory_stage: driver issues ops and pushes
// expected writeback records; a negedge monitor pops and compares them.
module tb_memory_stage;

    localparam int W = 133; // {ir, pc, result, rw, exc, halt, chk_res}

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [63:0] ir_i;
    logic [31:0] pc_i, result_i, reg_data1_i, bus_dat_i;
    logic [1:0]  reg_write_i;
    logic        halt_i, bus_ack_i, bus_err_i;
    logic [63:0] ir_o;
    logic [31:0] pc_o, result_o, bus_adr_o, bus_dat_o;
    logic [1:0]  reg_write_o;
    logic        halt_o, stall_o, exc_o, bus_cyc_o, bus_stb_o, bus_we_o;
    logic [3:0]  bus_sel_o;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         exp_halt = 1'b0;

    memory_stage #(.AWIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .ir_i(ir_i), .pc_i(pc_i), .result_i(result_i),
        .reg_data1_i(reg_data1_i), .reg_write_i(reg_write_i), .halt_i(halt_i),
        .ir_o(ir_o), .pc_o(pc_o), .result_o(result_o), .reg_write_o(reg_write_o),
        .halt_o(halt_o), .stall_o(stall_o), .exc_o(exc_o), .bus_cyc_o(bus_cyc_o),
        .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
        .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
        .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
    );

    // ---- clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ir_i = '0; pc_i = '0; result_i = '0; reg_data1_i = '0;
        reg_write_i = '0; halt_i = 1'b0;
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_dat_i = '0;
    endtask

    // ---- driver: one instruction, acting as bus slave when a cycle appears
    task automatic run_op(input string nm, input logic [63:0] ir, input logic [31:0] pc,
                          input logic [31:0] res, input logic [31:0] d, input logic [1:0] rw,
                          input logic h, input int waits, input logic ack, input logic err,
                          input logic [31:0] rdat, input logic exp_bus, input logic exp_we,
                          input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                          input logic [31:0] exp_res, input logic [1:0] exp_rw,
                          input logic exp_exc, input logic chk_res, input int exp_stall);
        int  stall_cnt = 0;
        int  bw = 0;
        logic bus_seen = 1'b0;
        logic done = 1'b0;
        exp_halt = exp_halt | h;
        exp_q.push_back({ir, pc, exp_res, exp_rw, exp_exc, exp_halt, chk_res});
        ir_i = ir; pc_i = pc; result_i = res; reg_data1_i = d; reg_write_i = rw; halt_i = h;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus_cyc_o) begin
                if (!bus_seen) begin
                    chk({nm, " adr"}, 64'(bus_adr_o), 64'(res));
                    chk({nm, " sel"}, 64'(bus_sel_o), 64'(exp_sel));
                    chk({nm, " we"}, 64'(bus_we_o), 64'(exp_we));
                    if (exp_we) chk({nm, " dat_o"}, 64'(bus_dat_o), 64'(exp_dat));
                end
                chk({nm, " stb"}, 64'(bus_stb_o), 64'(bus_cyc_o));
                bus_seen = 1'b1;
                if (bw == waits) begin
                    bus_ack_i = ack; bus_err_i = err; bus_dat_i = rdat;
                end
                bw++;
            end
            @(negedge clk);
            if (!stall_o) done = 1'b1;
            else stall_cnt++;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        if (!done) chk({nm, " stall bound"}, 64'(stall_cnt), 64'(exp_stall));
        @(posedge clk); #1;
        clear_inputs();
        chk({nm, " stall cycles"}, 64'(stall_cnt), 64'(exp_stall));
        chk({nm, " bus cycle"}, 64'(bus_seen), 64'(exp_bus));
        chk({nm, " cyc after"}, 64'(bus_cyc_o), 64'd0);
    endtask

    // ---- scoreboard monitor
    always @(negedge clk) begin
        if (rst_ni && ir_o != 64'h0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected output: ir_o %h with empty queue", ir_o);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("out ir", ir_o, e[132:69]);
                chk("out pc", 64'(pc_o), 64'(e[68:37]));
                if (e[0]) chk("out result", 64'(result_o), 64'(e[36:5]));
                chk("out reg_write", 64'(reg_write_o), 64'(e[4:3]));
                chk("out exc", 64'(exc_o), 64'(e[2]));
                chk("out halt", 64'(halt_o), 64'(e[1]));
            end
        end
    end

    // ---- stimulus
    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst ir_o", ir_o, 64'h0);
        chk("rst result_o", 64'(result_o), 64'h0);
        chk("rst cyc/stb/stall/exc/halt", 64'({bus_cyc_o, bus_stb_o, stall_o, exc_o, halt_o}), 64'h0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        run_op("alu", 64'h0000_0000_6000_0123, 32'h10, 32'h1234, 32'h0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, 32'h1234, 2'b01, 1'b0, 1'b1, 0);
        run_op("ld_word", 64'h0000_0000_9000_0456, 32'h20, 32'h100, 32'h0, 2'b01, 1'b0, 3, 1'b1, 1'b0, 32'hDEADBEEF,
               1'b1, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 2'b01, 1'b0, 1'b1, 4);
        run_op("st_byte", 64'h1111_2222_A200_0011, 32'h24, 32'h103, 32'h0000_00A5, 2'b00, 1'b0, 0, 1'b1, 1'b0, 32'h0,
               1'b1, 1'b1, 4'b0001, 32'hA5A5A5A5, 32'h103, 2'b00, 1'b0, 1'b1, 1);
        run_op("st_half", 64'h0000_0000_A100_0012, 32'h28, 32'h2, 32'h1234_BEEF, 2'b00, 1'b0, 0, 1'b1, 1'b0, 32'h0,
               1'b1, 1'b1, 4'b0011, 32'hBEEFBEEF, 32'h2, 2'b00, 1'b0, 1'b1, 1);
        run_op("ld_half", 64'h0000_0000_9100_0022, 32'h2C, 32'h2, 32'h0, 2'b01, 1'b0, 1, 1'b1, 1'b0, 32'h11223344,
               1'b1, 1'b0, 4'b0011, 32'h0, 32'h0000_3344, 2'b01, 1'b0, 1'b1, 2);
        run_op("ld_byte", 64'h0000_0000_9200_0023, 32'h30, 32'h101, 32'h0, 2'b01, 1'b0, 0, 1'b1, 1'b0, 32'hAABBCCDD,
               1'b1, 1'b0, 4'b0100, 32'h0, 32'h0000_00BB, 2'b01, 1'b0, 1'b1, 1);
        run_op("st_word11", 64'h0000_0000_A300_0024, 32'h34, 32'h104, 32'hCAFEF00D, 2'b00, 1'b0, 2, 1'b1, 1'b0, 32'h0,
               1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 32'h104, 2'b00, 1'b0, 1'b1, 3);
        run_op("mis_half", 64'h0000_0000_9100_0033, 32'h38, 32'h101, 32'h0, 2'b01, 1'b0, 0, 1'b1, 1'b0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 0);
        run_op("mis_word", 64'h0000_0000_9300_0034, 32'h3C, 32'h102, 32'h0, 2'b01, 1'b0, 0, 1'b1, 1'b0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 0);
        run_op("err_ack", 64'h0000_0000_9000_0035, 32'h40, 32'h300, 32'h0, 2'b01, 1'b0, 0, 1'b1, 1'b1, 32'h12345678,
               1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1);
        run_op("halt_set", 64'h0000_0000_6000_0001, 32'h44, 32'h7, 32'h0, 2'b01, 1'b1, 0, 1'b0, 1'b0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, 32'h7, 2'b01, 1'b0, 1'b1, 0);
        run_op("halt_sticky", 64'h0000_0000_6000_0002, 32'h48, 32'h8, 32'h0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, 32'h8, 2'b01, 1'b0, 1'b1, 0);

        // Reset asserted while a load waits on the bus.
        ir_i = 64'h0000_0000_9000_0040; pc_i = 32'h50; result_i = 32'h200; reg_write_i = 2'b01;
        @(posedge clk); #1;
        chk("midbus cyc", 64'(bus_cyc_o), 64'd1);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        chk("midbus rst cyc", 64'(bus_cyc_o), 64'd0);
        chk("midbus rst stb", 64'(bus_stb_o), 64'd0);
        chk("midbus rst stall", 64'(stall_o), 64'd0);
        chk("midbus rst halt", 64'(halt_o), 64'd0);
        clear_inputs();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        exp_halt = 1'b0;
        @(posedge clk); #1;
        run_op("mov", 64'h0000_0000_4000_0003, 32'h60, 32'h55, 32'h0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, 32'h55, 2'b01, 1'b0, 1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
